d2d_link_tx_framer: RTL and testbench

- Downstream neighbour of the D2D adapter: consumes its dst-side word stream (32-bit data plus 16-bit address, valid/ready).
- Buffers each word in a small FIFO and serializes it into an 8-byte frame on an 8-bit die-to-die link.
- Frame = header, address, data, check byte; link side has its own valid/ready backpressure.

---
 rtl/d2d_link_tx_framer.sv | 152 +++++++++++++++
 tb/tb_d2d_link_tx_framer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/d2d_link_tx_framer.sv
// Word-to-byte framer for the die-to-die TX link: small input FIFO feeding an 8-beat frame serializer.
// Optional macro D2D_TX_CRC8_EN selects a CRC-8 (poly 0x07) check byte instead of the XOR check byte.
module d2d_link_tx_framer #(
    parameter int          DEPTH     = 2,
    parameter logic [3:0]  HDR_MAGIC = 4'h5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] srcData,
    input  logic [15:0] srcAddr,
    input  logic        srcValid,
    output logic        srcReady,
    output logic [7:0]  linkData,
    output logic        linkValid,
    input  logic        linkReady,
    output logic        linkSof,
    output logic        linkEof,
    output logic        busy,
    output logic [15:0] frameCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_mem_data [DEPTH];
    logic [15:0]     r_mem_addr [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [3:0]      r_seq;
    logic [15:0]     r_frame_count;
    logic [2:0]      r_beat;
    logic [63:0]     r_frame;

    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_push;
    logic            w_pop;
    logic            w_accept;
    logic            w_last;
    logic [3:0]      w_hdr_seq;
    logic [55:0]     w_body;
    logic [7:0]      w_body_bytes [7];
    logic [7:0]      w_check;
    logic [5:0]      w_shift;

    function automatic logic [7:0] check_byte(input logic [7:0] bytes [7]);
        logic [7:0] c;
        c = 8'h00;
`ifdef D2D_TX_CRC8_EN
        for (int i = 0; i < 7; i++) begin
            c = c ^ bytes[i];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
`else
        for (int i = 0; i < 7; i++) begin
            c = c ^ bytes[i];
        end
`endif
        return c;
    endfunction

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CW'(DEPTH));
    assign srcReady     = !reset && !w_fifo_full;
    assign w_push       = srcValid && srcReady;
    assign w_accept     = linkValid && linkReady;
    assign w_last       = w_accept && (r_beat == 3'd7);
    assign w_pop        = !w_fifo_empty && ((r_state == S_IDLE) || w_last);

    // A pop in SEND only happens as the previous frame retires, so its header takes the next seq.
    assign w_hdr_seq = (r_state == S_SEND) ? (r_seq + 4'd1) : r_seq;
    assign w_body    = {HDR_MAGIC, w_hdr_seq, r_mem_addr[r_rd_ptr], r_mem_data[r_rd_ptr]};

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_body_bytes
            assign w_body_bytes[gi] = w_body[55-8*gi -: 8];
        end
    endgenerate

    assign w_check = check_byte(w_body_bytes);
    assign w_shift = {3'd7 - r_beat, 3'b000};

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= srcData;
            r_mem_addr[r_wr_ptr] <= srcAddr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_seq         <= 4'd0;
            r_frame_count <= 16'd0;
            r_beat        <= 3'd0;
            r_frame       <= 64'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_pop) begin
                r_frame <= {w_body, w_check};
                r_beat  <= 3'd0;
            end else if (w_accept) begin
                r_beat  <= r_beat + 3'd1;
            end
            if (w_last) begin
                r_seq         <= r_seq + 4'd1;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_fifo_empty) w_state_next = S_SEND;
            S_SEND:  if (w_last && w_fifo_empty) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        linkValid = (r_state == S_SEND);
        linkData  = 8'h00;
        linkSof   = 1'b0;
        linkEof   = 1'b0;
        if (r_state == S_SEND) begin
            linkData = r_frame[w_shift +: 8];
            linkSof  = (r_beat == 3'd0);
            linkEof  = (r_beat == 3'd7);
        end
    end

    assign busy       = !w_fifo_empty || (r_state == S_SEND);
    assign frameCount = r_frame_count;

endmodule

// File: tb/tb_d2d_link_tx_framer.sv
// Directed bench for d2d_link_tx_framer: reset, single frames, back-to-back, backpressure, seq wrap, mid-frame reset.
module tb_d2d_link_tx_framer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] srcData;
    logic [15:0] srcAddr;
    logic        srcValid;
    logic        srcReady;
    logic [7:0]  linkData;
    logic        linkValid;
    logic        linkReady;
    logic        linkSof;
    logic        linkEof;
    logic        busy;
    logic [15:0] frameCount;

    int checks = 0;
    int errors = 0;

    d2d_link_tx_framer #(.DEPTH(2), .HDR_MAGIC(4'h5)) dut (
        .clock(clock), .reset(reset),
        .srcData(srcData), .srcAddr(srcAddr), .srcValid(srcValid), .srcReady(srcReady),
        .linkData(linkData), .linkValid(linkValid), .linkReady(linkReady),
        .linkSof(linkSof), .linkEof(linkEof), .busy(busy), .frameCount(frameCount)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-8 (poly 0x07) used only when the CRC build is selected.
    function automatic logic [7:0] crc_bits(input logic [55:0] msg);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 55; i >= 0; i--) begin
            fb = c[7] ^ msg[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_chk(input logic [55:0] body, input logic [7:0] hand_xor);
`ifdef D2D_TX_CRC8_EN
        return crc_bits(body);
`else
        return (body[0] === 1'bx) ? 8'hxx : hand_xor;
`endif
    endfunction

    function automatic logic [63:0] mkframe(input logic [7:0] hdr, input logic [15:0] addr,
                                            input logic [31:0] data, input logic [7:0] hand_xor);
        return {hdr, addr, data, exp_chk({hdr, addr, data}, hand_xor)};
    endfunction

    task automatic check_beat(input int i, input logic [7:0] e);
        chk($sformatf("beat%0d_valid", i), {31'd0, linkValid}, 32'd1);
        chk($sformatf("beat%0d_data", i), {24'd0, linkData}, {24'd0, e});
        chk($sformatf("beat%0d_sof", i), {31'd0, linkSof}, {31'd0, (i == 0)});
        chk($sformatf("beat%0d_eof", i), {31'd0, linkEof}, {31'd0, (i == 7)});
    endtask

    task automatic push(input logic [15:0] a, input logic [31:0] d);
        srcAddr  = a;
        srcData  = d;
        srcValid = 1'b1;
        chk("push_ready", {31'd0, srcReady}, 32'd1);
        tick();
        srcValid = 1'b0;
    endtask

    task automatic send_frame(input string name, input logic [63:0] fr, input logic [15:0] fc);
        push(fr[55:40], fr[39:8]);
        chk({name, "_idle_after_push"}, {31'd0, linkValid}, 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_beat(i, fr[63-8*i -: 8]);
            tick();
        end
        chk({name, "_frame_count"}, {16'd0, frameCount}, {16'd0, fc});
        chk({name, "_busy_clear"}, {31'd0, busy}, 32'd0);
        chk({name, "_valid_clear"}, {31'd0, linkValid}, 32'd0);
        $display("frame %s: hdr=%h chk=%h frameCount=%0d", name, fr[63:56], fr[7:0], frameCount);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        chk("rst_srcReady", {31'd0, srcReady}, 32'd0);
        chk("rst_frameCount", {16'd0, frameCount}, 32'd0);
        reset = 1'b0;
        tick();
    endtask

    logic [63:0] fr3 [3];
    logic [63:0] fr;
    logic [7:0]  hdr;

    initial begin
        reset     = 1'b1;
        srcValid  = 1'b0;
        srcData   = '0;
        srcAddr   = '0;
        linkReady = 1'b1;
        tick();
        tick();
        chk("reset_srcReady", {31'd0, srcReady}, 32'd0);
        chk("reset_linkValid", {31'd0, linkValid}, 32'd0);
        chk("reset_sof", {31'd0, linkSof}, 32'd0);
        chk("reset_eof", {31'd0, linkEof}, 32'd0);
        chk("reset_linkData", {24'd0, linkData}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_frameCount", {16'd0, frameCount}, 32'd0);
        reset = 1'b0;
        tick();
        chk("release_srcReady", {31'd0, srcReady}, 32'd1);

        send_frame("basic", mkframe(8'h50, 16'h0001, 32'hA5A5A5A5, 8'h51), 16'd1);

        reset_pulse();
`ifdef D2D_TX_CRC8_EN
        fr = {8'h50, 48'h0, 8'h96};
`else
        fr = {8'h50, 48'h0, 8'h50};
`endif
        send_frame("zero", fr, 16'd1);

        // Three words back-to-back: the third push fills the FIFO while frame A is on the link.
        reset_pulse();
        fr3[0] = mkframe(8'h50, 16'h1111, 32'h11223344, 8'h14);
        fr3[1] = mkframe(8'h51, 16'h2222, 32'h55667788, 8'h9D);
        fr3[2] = mkframe(8'h52, 16'h3333, 32'h99AABBCC, 8'h16);
        push(fr3[0][55:40], fr3[0][39:8]);
        push(fr3[1][55:40], fr3[1][39:8]);
        for (int j = 0; j < 24; j++) begin
            fr = fr3[j/8];
            check_beat(j % 8, fr[63-8*(j%8) -: 8]);
            if (j == 0) begin
                srcAddr  = fr3[2][55:40];
                srcData  = fr3[2][39:8];
                srcValid = 1'b1;
                chk("b2b_ready_before_full", {31'd0, srcReady}, 32'd1);
            end
            tick();
            if (j == 0) begin
                srcValid = 1'b0;
                chk("b2b_full_not_ready", {31'd0, srcReady}, 32'd0);
            end
        end
        chk("b2b_frame_count", {16'd0, frameCount}, 32'd3);
        chk("b2b_busy_clear", {31'd0, busy}, 32'd0);
        $display("b2b: 24 beats, frameCount=%0d", frameCount);

        // Backpressure at beat 3 for five cycles.
        fr = mkframe(8'h53, 16'hBEEF, 32'hDEADC0DE, 8'h6F);
        push(fr[55:40], fr[39:8]);
        tick();
        for (int i = 0; i < 3; i++) begin
            check_beat(i, fr[63-8*i -: 8]);
            tick();
        end
        check_beat(3, 8'hDE);
        linkReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_beat(3, 8'hDE);
        end
        linkReady = 1'b1;
        for (int i = 3; i < 8; i++) begin
            check_beat(i, fr[63-8*i -: 8]);
            tick();
        end
        chk("bp_frame_count", {16'd0, frameCount}, 32'd4);
        $display("backpressure: hold 5 cycles at beat 3, frameCount=%0d", frameCount);

        // Seq wrap: 17 frames after reset, the last header returns to 0x50.
        reset_pulse();
        for (int f = 0; f < 17; f++) begin
            hdr = {4'h5, 4'(f)};
            send_frame($sformatf("wrap%0d", f),
                       mkframe(hdr, 16'(f), 32'h0, (f < 16) ? 8'h50 : 8'h40), 16'(f + 1));
        end

        // Reset at beat 4 with a second word queued.
        push(16'h4444, 32'h01234567);
        push(16'h5555, 32'h89ABCDEF);
        chk("midrst_hdr", {24'd0, linkData}, 32'h51);
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_beat4", {24'd0, linkData}, 32'h23);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, linkValid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_eof", {31'd0, linkEof}, 32'd0);
        reset = 1'b0;
        tick();
        chk("midrst_fc_after", {16'd0, frameCount}, 32'd0);
        chk("midrst_still_idle", {31'd0, linkValid}, 32'd0);
`ifdef D2D_TX_CRC8_EN
        fr = {8'h50, 48'h0, 8'h96};
`else
        fr = {8'h50, 48'h0, 8'h50};
`endif
        send_frame("after_midrst", fr, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
